// File: rtl/dds_sweep_block.sv
// Single-channel DDS: APB register file, loadable waveform LUT, chirp sweep
// sequencer and a saturating Q8.8 gain stage feeding the DAC-side mux.

module dds_sweep_regs #(
   parameter int DATA_WIDTH     = 8,
   parameter int PHASE_WIDTH    = 32,
   parameter int LUT_ADDR_WIDTH = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [31:0]               paddr,
   input  logic [31:0]               pwdata,
   input  logic [1:0]                state,
   input  logic                      sweep_done,
   input  logic [PHASE_WIDTH-1:0]    cur_step,
   output logic [31:0]               prdata,
   output logic                      enable,
   output logic                      sweep_en,
   output logic                      triangle,
   output logic                      single_shot,
   output logic [PHASE_WIDTH-1:0]    step_start,
   output logic [PHASE_WIDTH-1:0]    step_stop,
   output logic [PHASE_WIDTH-1:0]    step_delta,
   output logic [PHASE_WIDTH-1:0]    phase_ofs,
   output logic [31:0]               dwell,
   output logic signed [15:0]        gain,
   output logic                      ctrl_wr,
   output logic                      phase_clr,
   output logic                      lut_we,
   output logic [LUT_ADDR_WIDTH-1:0] lut_waddr,
   output logic [DATA_WIDTH-1:0]     lut_wdata
);
   localparam logic [5:0] A_CTRL   = 6'h00;
   localparam logic [5:0] A_START  = 6'h01;
   localparam logic [5:0] A_STOP   = 6'h02;
   localparam logic [5:0] A_DELTA  = 6'h03;
   localparam logic [5:0] A_DWELL  = 6'h04;
   localparam logic [5:0] A_OFS    = 6'h05;
   localparam logic [5:0] A_GAIN   = 6'h06;
   localparam logic [5:0] A_LUT    = 6'h07;
   localparam logic [5:0] A_STATUS = 6'h08;
   localparam logic [5:0] A_CUR    = 6'h09;

   logic       wr_en;
   logic [5:0] addr;
   logic       unused_paddr;

   assign addr         = paddr[7:2];
   assign wr_en        = psel & penable & pwrite;
   assign ctrl_wr      = wr_en & (addr == A_CTRL);
   assign phase_clr    = ctrl_wr & pwdata[4];
   assign lut_we       = wr_en & ~reset & (addr == A_LUT);
   assign lut_waddr    = pwdata[16 +: LUT_ADDR_WIDTH];
   assign lut_wdata    = pwdata[DATA_WIDTH-1:0];
   assign unused_paddr = ^{paddr[31:8], paddr[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         {single_shot, triangle, sweep_en, enable} <= 4'b0000;
         step_start <= '0;
         step_stop  <= '0;
         step_delta <= '0;
         phase_ofs  <= '0;
         dwell      <= '0;
         gain       <= 16'sh0100;
      end else if (wr_en) begin
         case (addr)
            A_CTRL:  {single_shot, triangle, sweep_en, enable} <= pwdata[3:0];
            A_START: step_start <= pwdata[PHASE_WIDTH-1:0];
            A_STOP:  step_stop  <= pwdata[PHASE_WIDTH-1:0];
            A_DELTA: step_delta <= pwdata[PHASE_WIDTH-1:0];
            A_DWELL: dwell      <= pwdata;
            A_OFS:   phase_ofs  <= pwdata[PHASE_WIDTH-1:0];
            A_GAIN:  gain       <= pwdata[15:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      prdata = '0;
      case (addr)
         A_CTRL:   prdata = {28'd0, single_shot, triangle, sweep_en, enable};
         A_START:  prdata = 32'(step_start);
         A_STOP:   prdata = 32'(step_stop);
         A_DELTA:  prdata = 32'(step_delta);
         A_DWELL:  prdata = dwell;
         A_OFS:    prdata = 32'(phase_ofs);
         A_GAIN:   prdata = {16'd0, gain};
         A_STATUS: prdata = {29'd0, sweep_done, state};
         A_CUR:    prdata = 32'(cur_step);
         default:  prdata = '0;
      endcase
   end
endmodule

module dds_sweep_block #(
   parameter int DATA_WIDTH     = 8,
   parameter int PHASE_WIDTH    = 32,
   parameter int LUT_ADDR_WIDTH = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [31:0]                  paddr,
   input  logic [31:0]                  pwdata,
   output logic [31:0]                  prdata,
   output logic signed [DATA_WIDTH-1:0] dds_out,
   output logic                         dds_out_valid,
   output logic                         sweep_done
);
   // state | meaning
   // IDLE  | cur_step follows STEP_START, waiting for sweep_en
   // UP    | stepping cur_step up by DELTA per dwell towards STOP
   // DOWN  | stepping cur_step down by DELTA per dwell towards START
   // DONE  | single-shot finished, cur_step held, sweep_done high
   typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, DONE = 2'd3} sweep_state_t;

   localparam int PW = PHASE_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam logic signed [DW+16:0] RND_HALF = (DW+17)'(128);
   localparam logic signed [DW+16:0] SAT_MAX  = {{18{1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [DW+16:0] SAT_MIN  = {{18{1'b1}}, {(DW-1){1'b0}}};

   sweep_state_t state;
   logic                      enable, sweep_en, triangle, single_shot;
   logic [PW-1:0]             step_start, step_stop, step_delta, phase_ofs, cur_step, phase;
   logic [31:0]               dwell, dwell_cnt, dwell_m1;
   logic signed [15:0]        gain;
   logic                      ctrl_wr, phase_clr, lut_we, dwell_tc, up_hit, dn_hit;
   logic [LUT_ADDR_WIDTH-1:0] lut_waddr, lut_raddr;
   logic [DW-1:0]             lut_wdata;
   logic [DW-1:0]             lut_mem [2**LUT_ADDR_WIDTH];
   logic signed [DW-1:0]      lut_q, sat_val;
   logic signed [DW+15:0]     prod;
   logic signed [DW+16:0]     rnd, shifted;
   logic [PW:0]               up_sum, dn_lim;
   logic [1:0]                vld_pipe;

   dds_sweep_regs #(
      .DATA_WIDTH(DATA_WIDTH), .PHASE_WIDTH(PHASE_WIDTH), .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH)
   ) u_regs (
      .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .state(state), .sweep_done(sweep_done),
      .cur_step(cur_step), .prdata(prdata), .enable(enable), .sweep_en(sweep_en),
      .triangle(triangle), .single_shot(single_shot), .step_start(step_start),
      .step_stop(step_stop), .step_delta(step_delta), .phase_ofs(phase_ofs),
      .dwell(dwell), .gain(gain), .ctrl_wr(ctrl_wr), .phase_clr(phase_clr),
      .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata)
   );

   assign lut_raddr = LUT_ADDR_WIDTH'((phase + phase_ofs) >> (PW - LUT_ADDR_WIDTH));

   always_ff @(posedge clk) begin
      if (lut_we) lut_mem[lut_waddr] <= lut_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase         <= '0;
         lut_q         <= '0;
         prod          <= '0;
         vld_pipe      <= '0;
         dds_out       <= '0;
         dds_out_valid <= 1'b0;
      end else begin
         if (phase_clr)   phase <= '0;
         else if (enable) phase <= phase + cur_step;
         lut_q         <= lut_mem[lut_raddr];
         prod          <= (DW+16)'(lut_q) * (DW+16)'(gain);
         vld_pipe      <= {vld_pipe[0], enable};
         dds_out_valid <= vld_pipe[1];
         if (vld_pipe[1]) dds_out <= sat_val;
      end
   end

   assign rnd     = (DW+17)'(prod) + RND_HALF;
   assign shifted = rnd >>> 8;

   always_comb begin
      sat_val = shifted[DW-1:0];
      if (shifted > SAT_MAX)      sat_val = SAT_MAX[DW-1:0];
      else if (shifted < SAT_MIN) sat_val = SAT_MIN[DW-1:0];
   end

   // Sweep compares are done one bit wider so START/STOP near full scale never wrap.
   assign up_sum   = {1'b0, cur_step} + {1'b0, step_delta};
   assign dn_lim   = {1'b0, step_start} + {1'b0, step_delta};
   assign up_hit   = up_sum >= {1'b0, step_stop};
   assign dn_hit   = {1'b0, cur_step} < dn_lim;
   assign dwell_m1 = (dwell == 32'd0) ? 32'd0 : dwell - 32'd1;
   assign dwell_tc = (dwell_cnt == 32'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cur_step   <= '0;
         dwell_cnt  <= '0;
         sweep_done <= 1'b0;
      end else begin
         sweep_done <= 1'b0;
         dwell_cnt  <= dwell_tc ? dwell_m1 : dwell_cnt - 32'd1;
         if (!sweep_en) begin
            state     <= IDLE;
            cur_step  <= step_start;
            dwell_cnt <= dwell_m1;
         end else begin
            case (state)
               IDLE: begin
                  state     <= UP;
                  cur_step  <= step_start;
                  dwell_cnt <= dwell_m1;
               end
               UP: begin
                  if (step_start > step_stop) begin
                     state      <= DONE;
                     cur_step   <= step_start;
                     sweep_done <= 1'b1;
                     dwell_cnt  <= dwell_m1;
                  end else if (dwell_tc) begin
                     if (!up_hit) cur_step <= up_sum[PW-1:0];
                     else if (triangle) begin
                        cur_step <= step_stop;
                        state    <= DOWN;
                     end else if (single_shot) begin
                        cur_step   <= step_stop;
                        state      <= DONE;
                        sweep_done <= 1'b1;
                     end else if (cur_step >= step_stop) cur_step <= step_start;
                     else cur_step <= step_stop;
                  end
               end
               DOWN: begin
                  if (dwell_tc) begin
                     if (dn_hit) begin
                        cur_step <= step_start;
                        if (single_shot) begin
                           state      <= DONE;
                           sweep_done <= 1'b1;
                        end else state <= UP;
                     end else cur_step <= cur_step - step_delta;
                  end
               end
               DONE: begin
                  sweep_done <= 1'b1;
                  if (ctrl_wr) begin
                     sweep_done <= 1'b0;
                     cur_step   <= step_start;
                     dwell_cnt  <= dwell_m1;
                     state      <= (pwdata[1] & pwdata[3]) ? UP : IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_dds_sweep_block.sv
// Bench for dds_sweep_block: tone pipeline, gain saturation, sweep sequences,
// reset abort; expected values queued at stimulus time and popped on output.

module tb_dds_sweep_block;
   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0]       paddr = '0, pwdata = '0;
   logic [31:0]       prdata;
   logic signed [7:0] dds_out;
   logic              dds_out_valid, sweep_done;

   int                n_checks = 0;
   int                n_errors = 0;
   logic signed [63:0] exp_q[$];
   logic [7:0]        lut_m [1024];

   logic [7:0]  sat_lut  [6] = '{8'h7F, 8'h80, 8'h01, 8'hF6, 8'h40, 8'h7F};
   logic [15:0] sat_gain [6] = '{16'h0200, 16'h0200, 16'h0080, 16'h0180, 16'hFF00, 16'hFE00};
   int          sat_exp  [6] = '{127, -128, 1, -15, -64, -128};
   int          saw_seq  [6] = '{100, 110, 120, 130, 100, 110};
   int          tri_seq  [7] = '{100, 110, 120, 130, 120, 110, 100};

   always #5 clk = ~clk;

   dds_sweep_block dut (
      .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .dds_out(dds_out),
      .dds_out_valid(dds_out_valid), .sweep_done(sweep_done)
   );

   task automatic check_val(input string tag, input logic signed [63:0] act,
                            input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
      paddr = a;
      #1;
      d = prdata;
   endtask

   task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
      logic [31:0] s;
      int n = 0;
      read_reg(32'h20, s);
      while (s[1:0] != st && n < budget) begin
         @(negedge clk);
         read_reg(32'h20, s);
         n++;
      end
      check_val(tag, s[1:0], st);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      int lat, n;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_val("rst_dds_out", $signed(dds_out), 0);
      check_val("rst_valid", dds_out_valid, 0);
      check_val("rst_sweep_done", sweep_done, 0);
      read_reg(32'h20, d); check_val("rst_status", d, 0);
      read_reg(32'h24, d); check_val("rst_cur_step", d, 0);
      read_reg(32'h18, d); check_val("rst_gain", d, 32'h0100);

      for (int i = 0; i < 1024; i++) begin
         lut_m[i] = 8'(i);
         apb_write(32'h1C, (32'(i) << 16) | 32'(i & 255));
      end

      // static tone: one LUT entry per cycle
      apb_write(32'h04, 32'h0040_0000);
      for (int k = 0; k < 20; k++) exp_q.push_back($signed(lut_m[k]));
      apb_write(32'h00, 32'h1);
      lat = 0;
      while (!dds_out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_val("tone_latency", lat, 3);
      n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         if (dds_out_valid) check_val("tone_sample", $signed(dds_out), exp_q.pop_front());
         @(negedge clk);
         n++;
      end
      check_val("tone_drain", exp_q.size(), 0);
      apb_write(32'h00, 32'h0);
      repeat (5) @(negedge clk);
      check_val("tone_valid_off", dds_out_valid, 0);

      // gain stage: zero step, phase cleared, offset selects LUT entry
      apb_write(32'h04, 32'h0);
      apb_write(32'h00, 32'h10);
      apb_write(32'h00, 32'h1);
      for (int i = 0; i < 6; i++) begin
         apb_write(32'h1C, (32'(i) << 16) | 32'(sat_lut[i]));
         apb_write(32'h18, 32'(sat_gain[i]));
         apb_write(32'h14, 32'(i) << 22);
         exp_q.push_back(sat_exp[i]);
         repeat (6) @(negedge clk);
         check_val("gain_sat", $signed(dds_out), exp_q.pop_front());
      end
      check_val("gain_valid", dds_out_valid, 1);

      // sawtooth
      apb_write(32'h00, 32'h0);
      apb_write(32'h04, 100);
      apb_write(32'h08, 130);
      apb_write(32'h0C, 10);
      apb_write(32'h10, 4);
      foreach (saw_seq[i]) repeat (4) exp_q.push_back(saw_seq[i]);
      apb_write(32'h00, 32'h2);
      wait_state(2'd1, 10, "saw_enter_up");
      for (int k = 0; k < 24; k++) begin
         read_reg(32'h24, d);
         check_val("saw_cur_step", d, exp_q.pop_front());
         @(negedge clk);
      end
      check_val("saw_no_done", sweep_done, 0);

      // triangle single-shot
      apb_write(32'h00, 32'h0);
      wait_state(2'd0, 5, "tri_idle");
      foreach (tri_seq[i]) repeat (4) exp_q.push_back(tri_seq[i]);
      apb_write(32'h00, 32'hE);
      wait_state(2'd1, 10, "tri_enter_up");
      for (int k = 0; k < 28; k++) begin
         read_reg(32'h24, d);
         check_val("tri_cur_step", d, exp_q.pop_front());
         @(negedge clk);
      end
      read_reg(32'h20, d); check_val("tri_status_done", d, 32'h7);
      check_val("tri_sweep_done", sweep_done, 1);
      repeat (8) @(negedge clk);
      read_reg(32'h24, d); check_val("tri_hold_step", d, 100);
      read_reg(32'h20, d); check_val("tri_hold_status", d, 32'h7);

      // restart from DONE
      apb_write(32'h00, 32'hE);
      read_reg(32'h20, d); check_val("restart_status", d, 32'h1);
      read_reg(32'h24, d); check_val("restart_step", d, 100);

      // START > STOP
      apb_write(32'h00, 32'h0);
      apb_write(32'h04, 200);
      apb_write(32'h08, 100);
      apb_write(32'h00, 32'h2);
      wait_state(2'd3, 10, "inv_done_state");
      read_reg(32'h24, d); check_val("inv_cur_step", d, 200);
      check_val("inv_sweep_done", sweep_done, 1);
      apb_write(32'h00, 32'h0);
      wait_state(2'd0, 3, "inv_back_idle");
      check_val("inv_done_clear", sweep_done, 0);

      // clear sweep_en mid-UP
      apb_write(32'h04, 100);
      apb_write(32'h08, 130);
      apb_write(32'h00, 32'h2);
      wait_state(2'd1, 10, "clr_enter_up");
      repeat (6) @(negedge clk);
      read_reg(32'h24, d); check_val("clr_mid_step", d, 110);
      apb_write(32'h00, 32'h0);
      wait_state(2'd0, 2, "clr_idle");
      read_reg(32'h24, d); check_val("clr_step_start", d, 100);

      // reset during DOWN with a write in flight
      apb_write(32'h18, 32'h0300);
      apb_write(32'h00, 32'h7);
      wait_state(2'd2, 40, "rst_reach_down");
      check_val("rst_pre_valid", dds_out_valid, 1);
      reset = 1'b1;
      psel = 1'b1; pwrite = 1'b1; penable = 1'b1; paddr = 32'h18; pwdata = 32'h55;
      @(negedge clk);
      reset = 1'b0;
      psel = 1'b0; pwrite = 1'b0; penable = 1'b0;
      check_val("rst2_dds_out", $signed(dds_out), 0);
      check_val("rst2_valid", dds_out_valid, 0);
      check_val("rst2_sweep_done", sweep_done, 0);
      read_reg(32'h20, d); check_val("rst2_status", d, 0);
      read_reg(32'h24, d); check_val("rst2_cur_step", d, 0);
      read_reg(32'h18, d); check_val("rst2_gain", d, 32'h0100);
      read_reg(32'h00, d); check_val("rst2_ctrl", d, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
